// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial pattern detector: overlap modes and the
// elaboration-time functions that derive the prefix-matching transition table.
package seq_det_pkg;

   localparam int MAX_PAT_LEN = 16;

   typedef enum logic {
      OVL_OFF = 1'b0,
      OVL_ON  = 1'b1
   } ovl_mode_e;

   // Longest prefix of pat that is a suffix of (first k pattern bits, then b).
   // Pattern bit len-1 is the first bit received.
   function automatic int next_len(input logic [15:0] pat, input int len,
                                   input int k, input logic b);
      int   best;
      int   si;
      logic ok;
      logic s_bit;
      best = 0;
      for (int j = 1; j <= MAX_PAT_LEN; j++) begin
         if (j <= k + 1 && j <= len) begin
            ok = 1'b1;
            for (int m = 0; m < MAX_PAT_LEN; m++) begin
               if (m < j) begin
                  si    = k + 1 - j + m;
                  s_bit = (si == k) ? b : pat[4'(len - 1 - si)];
                  if (pat[4'(len - 1 - m)] != s_bit)
                     ok = 1'b0;
               end
            end
            if (ok)
               best = j;
         end
      end
      return best;
   endfunction

   // Length of the longest proper border (prefix == suffix) of the pattern.
   function automatic int border_len(input logic [15:0] pat, input int len);
      int   best;
      logic ok;
      best = 0;
      for (int j = 1; j < MAX_PAT_LEN; j++) begin
         if (j < len) begin
            ok = 1'b1;
            for (int m = 0; m < MAX_PAT_LEN; m++) begin
               if (m < j && pat[4'(len - 1 - m)] != pat[4'(j - 1 - m)])
                  ok = 1'b0;
            end
            if (ok)
               best = j;
         end
      end
      return best;
   endfunction

endpackage

// File: rtl/seq_match_cnt.sv
// Saturating match counter with synchronous clear; clear wins over increment.
module seq_match_cnt #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt
);

   logic [CNT_W-1:0] cnt_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         cnt_reg <= '0;
      else if (clr)
         cnt_reg <= '0;
      else if (inc && cnt_reg != {CNT_W{1'b1}})
         cnt_reg <= cnt_reg + 1'b1;
   end

   assign cnt = cnt_reg;

endmodule

// File: rtl/seq_det_param.sv
// Parameterised serial pattern detector using an elaboration-time KMP table,
// with registered match pulse and saturating match counter.
module seq_det_param
   import seq_det_pkg::*;
#(
   parameter int                 PAT_LEN = 3,
   parameter logic [PAT_LEN-1:0] PATTERN = 3'b111,
   parameter int                 OVERLAP = 1,
   parameter int                 CNT_W   = 8,
   localparam int                SW      = $clog2(PAT_LEN + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             din,
   input  logic             clr_cnt,
   output logic             dout,
   output logic [SW-1:0]    state,
   output logic [CNT_W-1:0] match_cnt
);

   localparam int          NS      = 1 << SW;
   localparam logic [15:0] PAT16   = 16'(PATTERN);
   localparam logic [SW-1:0] RESTART =
      (OVERLAP == int'(OVL_ON)) ? SW'(border_len(PAT16, PAT_LEN)) : '0;

   // Reset asserts immediately but releases only after two clock edges.
   logic [1:0] sync_reg;
   logic       srst_n;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         sync_reg <= 2'b00;
      else
         sync_reg <= {sync_reg[0], 1'b1};
   end

   assign srst_n = sync_reg[1];

   // Table padded to a power of two so any state encoding indexes safely.
   logic [SW-1:0] nxt0 [NS];
   logic [SW-1:0] nxt1 [NS];

   for (genvar gi = 0; gi < NS; gi++) begin : g_tab
      if (gi < PAT_LEN) begin : g_live
         assign nxt0[gi] = SW'(next_len(PAT16, PAT_LEN, gi, 1'b0));
         assign nxt1[gi] = SW'(next_len(PAT16, PAT_LEN, gi, 1'b1));
      end else begin : g_pad
         assign nxt0[gi] = '0;
         assign nxt1[gi] = '0;
      end
   end

   logic [SW-1:0] state_reg, state_next;
   logic          dout_reg, dout_next;
   logic [SW-1:0] cand;
   logic          match;

   always_ff @(posedge clk or negedge srst_n) begin
      if (!srst_n) begin
         state_reg <= '0;
         dout_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         dout_reg  <= dout_next;
      end
   end

   always_comb begin
      cand       = din ? nxt1[state_reg] : nxt0[state_reg];
      match      = 1'b0;
      state_next = state_reg;
      dout_next  = 1'b0;
      if (en) begin
         if (cand == SW'(PAT_LEN)) begin
            match      = 1'b1;
            dout_next  = 1'b1;
            state_next = RESTART;
         end else begin
            state_next = cand;
         end
      end
   end

   seq_match_cnt #(
      .CNT_W(CNT_W)
   ) u_cnt (
      .clk(clk),
      .rst(srst_n),
      .inc(match),
      .clr(clr_cnt),
      .cnt(match_cnt)
   );

   assign dout  = dout_reg;
   assign state = state_reg;

endmodule

// File: tb/tb_seq_det_param.sv
// Directed table-driven bench for seq_det_param across several parameter sets.
module tb_seq_det_param;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic en = 1'b0;
   logic din = 1'b0;
   logic clr_cnt = 1'b0;

   always #5 clk = ~clk;

   logic       d0, d1, d2, d3, d4;
   logic [1:0] s0, s1, s3;
   logic [2:0] s2;
   logic [0:0] s4;
   logic [7:0] c0, c1, c2, c4;
   logic [1:0] c3;

   seq_det_param u0 (
      .clk(clk), .rst(rst), .en(en), .din(din), .clr_cnt(clr_cnt),
      .dout(d0), .state(s0), .match_cnt(c0));

   seq_det_param #(.PAT_LEN(3), .PATTERN(3'b111), .OVERLAP(0)) u1 (
      .clk(clk), .rst(rst), .en(en), .din(din), .clr_cnt(clr_cnt),
      .dout(d1), .state(s1), .match_cnt(c1));

   seq_det_param #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1)) u2 (
      .clk(clk), .rst(rst), .en(en), .din(din), .clr_cnt(clr_cnt),
      .dout(d2), .state(s2), .match_cnt(c2));

   seq_det_param #(.CNT_W(2)) u3 (
      .clk(clk), .rst(rst), .en(en), .din(din), .clr_cnt(clr_cnt),
      .dout(d3), .state(s3), .match_cnt(c3));

   seq_det_param #(.PAT_LEN(1), .PATTERN(1'b0)) u4 (
      .clk(clk), .rst(rst), .en(en), .din(din), .clr_cnt(clr_cnt),
      .dout(d4), .state(s4), .match_cnt(c4));

   typedef struct {
      logic rst_first;
      int   dut;
      logic en;
      logic din;
      logic clr;
      int   exp_dout;
      int   exp_state;
      int   exp_cnt;
   } vec_t;

   vec_t vecs[$];
   int   n_vec = 0;
   int   n_err = 0;

   function automatic int act_dout(input int d);
      case (d)
         0: return int'(d0);
         1: return int'(d1);
         2: return int'(d2);
         3: return int'(d3);
         default: return int'(d4);
      endcase
   endfunction

   function automatic int act_state(input int d);
      case (d)
         0: return int'(s0);
         1: return int'(s1);
         2: return int'(s2);
         3: return int'(s3);
         default: return int'(s4);
      endcase
   endfunction

   function automatic int act_cnt(input int d);
      case (d)
         0: return int'(c0);
         1: return int'(c1);
         2: return int'(c2);
         3: return int'(c3);
         default: return int'(c4);
      endcase
   endfunction

   function automatic void add(input logic r, input int d, input logic e,
                               input logic b, input logic c, input int xd,
                               input int xs, input int xc);
      vec_t v;
      v.rst_first = r; v.dut = d; v.en = e; v.din = b; v.clr = c;
      v.exp_dout = xd; v.exp_state = xs; v.exp_cnt = xc;
      vecs.push_back(v);
   endfunction

   task automatic chk(input string nm, input int d, input int act, input int exp);
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s dut%0d: got %0d expected %0d", nm, d, act, exp);
      end
   endtask

   task automatic chk_all(input string nm, input int d, input int xd,
                          input int xs, input int xc);
      n_vec++;
      chk({nm, ".dout"},  d, act_dout(d),  xd);
      chk({nm, ".state"}, d, act_state(d), xs);
      chk({nm, ".cnt"},   d, act_cnt(d),   xc);
      $display("%s dut%0d: dout=%0d state=%0d cnt=%0d", nm, d,
               act_dout(d), act_state(d), act_cnt(d));
   endtask

   task automatic step(input logic e, input logic b, input logic c);
      en = e; din = b; clr_cnt = c;
      @(posedge clk);
      #1;
   endtask

   // Async reset, then verify nothing moves during the two synchroniser edges.
   task automatic do_reset(input int d);
      rst = 1'b0; en = 1'b0; din = 1'b0; clr_cnt = 1'b0;
      #2;
      chk_all("reset", d, 0, 0, 0);
      @(posedge clk);
      #2;
      rst = 1'b1;
      step(1'b1, 1'b1, 1'b0);
      chk_all("sync_edge1", d, 0, 0, 0);
      step(1'b1, 1'b1, 1'b0);
      chk_all("sync_edge2", d, 0, 0, 0);
      en = 1'b0;
   endtask

   initial begin
      // Overlapping 111, five ones.
      add(1, 0, 1, 1, 0, 0, 1, 0);
      add(0, 0, 1, 1, 0, 0, 2, 0);
      add(0, 0, 1, 1, 0, 1, 2, 1);
      add(0, 0, 1, 1, 0, 1, 2, 2);
      add(0, 0, 1, 1, 0, 1, 2, 3);
      // Non-overlapping 111, six ones.
      add(1, 1, 1, 1, 0, 0, 1, 0);
      add(0, 1, 1, 1, 0, 0, 2, 0);
      add(0, 1, 1, 1, 0, 1, 0, 1);
      add(0, 1, 1, 1, 0, 0, 1, 1);
      add(0, 1, 1, 1, 0, 0, 2, 1);
      add(0, 1, 1, 1, 0, 1, 0, 2);
      // Pattern 1011 overlapping, stream 1011011.
      add(1, 2, 1, 1, 0, 0, 1, 0);
      add(0, 2, 1, 0, 0, 0, 2, 0);
      add(0, 2, 1, 1, 0, 0, 3, 0);
      add(0, 2, 1, 1, 0, 1, 1, 1);
      add(0, 2, 1, 0, 0, 0, 2, 1);
      add(0, 2, 1, 1, 0, 0, 3, 1);
      add(0, 2, 1, 1, 0, 1, 1, 2);
      // Enable gap holds state and ignores din.
      add(1, 0, 1, 1, 0, 0, 1, 0);
      add(0, 0, 1, 1, 0, 0, 2, 0);
      add(0, 0, 0, 0, 0, 0, 2, 0);
      add(0, 0, 0, 0, 0, 0, 2, 0);
      add(0, 0, 0, 0, 0, 0, 2, 0);
      add(0, 0, 1, 1, 0, 1, 2, 1);
      add(0, 0, 0, 1, 0, 0, 2, 1);
      // 2-bit counter saturates, then clear beats a coincident match.
      add(1, 3, 1, 1, 0, 0, 1, 0);
      add(0, 3, 1, 1, 0, 0, 2, 0);
      add(0, 3, 1, 1, 0, 1, 2, 1);
      add(0, 3, 1, 1, 0, 1, 2, 2);
      add(0, 3, 1, 1, 0, 1, 2, 3);
      add(0, 3, 1, 1, 0, 1, 2, 3);
      add(0, 3, 1, 1, 0, 1, 2, 3);
      add(0, 3, 1, 1, 1, 1, 2, 0);
      add(0, 3, 1, 1, 0, 1, 2, 1);
      add(0, 3, 1, 0, 1, 0, 0, 0);
      // Single-bit pattern 0.
      add(1, 4, 1, 0, 0, 1, 0, 1);
      add(0, 4, 1, 1, 0, 0, 0, 1);
      add(0, 4, 1, 0, 0, 1, 0, 2);
      add(0, 4, 1, 0, 0, 1, 0, 3);
      add(0, 4, 0, 0, 0, 0, 0, 3);

      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].rst_first)
            do_reset(vecs[i].dut);
         step(vecs[i].en, vecs[i].din, vecs[i].clr);
         chk_all($sformatf("vec%0d", i), vecs[i].dut,
                 vecs[i].exp_dout, vecs[i].exp_state, vecs[i].exp_cnt);
      end

      // Reset mid-pattern right after a match: outputs clear without a clock.
      do_reset(0);
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      chk_all("pre_rst", 0, 1, 2, 1);
      #2;
      rst = 1'b0;
      #1;
      chk_all("async_rst", 0, 0, 0, 0);
      @(posedge clk);
      #2;
      rst = 1'b1;
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      chk_all("post_rst", 0, 0, 1, 0);
      step(1'b1, 1'b1, 1'b0);
      chk_all("post_rst2", 0, 0, 2, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/seq_det_param.md
SEQ_DET_PARAM -- requirements
Module: seq_det_param

Interface
REQ-001 SHALL have parameter PAT_LEN, default 3, pattern length in bits, legal range 1..16.
REQ-002 SHALL have parameter PATTERN, default 3'b111, width PAT_LEN; bit PAT_LEN-1 is the first bit received.
REQ-003 SHALL have parameter OVERLAP, default 1; 1 = overlapping detection, 0 = non-overlapping.
REQ-004 SHALL have parameter CNT_W, default 8, match-counter width.
REQ-005 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port en, input, 1, din qualifier; din sampled only when en=1.
REQ-008 SHALL have port din, input, 1, serial data bit.
REQ-009 SHALL have port clr_cnt, input, 1, synchronous clear of match_cnt.
REQ-010 SHALL have port dout, output, 1, registered one-cycle match pulse.
REQ-011 SHALL have port state, output, SW=$clog2(PAT_LEN+1), current matched-prefix length.
REQ-012 SHALL have port match_cnt, output, CNT_W, saturating count of matches.

Function
REQ-013 State SHALL encode the number of pattern bits currently matched, range 0..PAT_LEN-1 after each edge.
REQ-014 On an edge with en=1, the candidate next state SHALL be the longest prefix of PATTERN that is a suffix of (matched prefix followed by din), i.e. KMP transition.
REQ-015 When the candidate equals PAT_LEN, it is a match: dout SHALL be 1 for exactly the following cycle.
REQ-016 On a match with OVERLAP=1, state SHALL load the length of the longest proper border of PATTERN (0 for no border).
REQ-017 On a match with OVERLAP=0, state SHALL load 0.
REQ-018 On an edge with en=0, state SHALL hold, dout SHALL be 0 and din SHALL be ignored.
REQ-019 dout SHALL be 0 in every cycle not directly following a match edge; back-to-back matches SHALL give consecutive high cycles.
REQ-020 match_cnt SHALL increment by 1 per match and saturate at 2^CNT_W-1 without wrapping.
REQ-021 clr_cnt=1 SHALL load match_cnt with 0 and take priority over a coincident match; dout SHALL still pulse for that match.
REQ-022 PAT_LEN=1 SHALL work: every sampled bit equal to PATTERN is a match, state stays 0.
REQ-023 Transition logic SHALL be computed at elaboration from PATTERN; no runtime pattern storage.

Reset
REQ-024 rst=0 SHALL asynchronously force state=0, dout=0, match_cnt=0, independent of clk.
REQ-025 Release of rst SHALL be synchronised so the first state update occurs no earlier than the second rising edge after deassertion.
REQ-026 Reset asserted mid-pattern SHALL discard the partial match; no pulse SHALL result from pre-reset bits.

Structure
REQ-027 Package seq_det_pkg SHALL hold the constant function computing the next-prefix-length transition and the border length, plus the OVERLAP mode constants.
REQ-028 The saturating counter SHALL be a sub-module seq_match_cnt (params CNT_W; ports clk, rst, inc, clr, cnt).
REQ-029 Default parameters SHALL reproduce the behaviour of an overlapping 111 detector with a 2-bit state.

Verification
REQ-030 Defaults, en=1, din=1,1,1,1,1 -> dout high after bits 3, 4 and 5; state 1,2,2,2,2; match_cnt=3.
REQ-031 OVERLAP=0, PATTERN=111, din=1 x6 -> dout after bits 3 and 6 only; state 1,2,0,1,2,0; match_cnt=2.
REQ-032 PAT_LEN=4, PATTERN=4'b1011, OVERLAP=1, din=1,0,1,1,0,1,1 -> dout after bits 4 and 7; state after bit 4 = 1; match_cnt=2.
REQ-033 Defaults, din=1,1 then en=0 for 3 cycles with din=0, then en=1 din=1 -> state holds 2, no pulse during gap, dout after final bit.
REQ-034 Defaults, din=1,1 then rst=0 between edges -> state, dout, match_cnt 0 immediately; after release, din=1 -> state 1, no pulse.
REQ-035 CNT_W=2, five matches -> match_cnt=3 (saturated); clr_cnt=1 coincident with a match -> match_cnt=0, dout pulses.
